// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side controller sitting behind the UART SIPO deserialiser. Each
// rising edge of the SIPO "frame received" level captures the parallel frame,
// checks start/parity/stop bits and, if the frame is good, queues the data
// byte in a small first-word-fall-through FIFO read by the host through a
// valid/ready handshake. Parity, framing, overrun and stuck-line conditions
// are reported as sticky error flags.
//
// Ports
//   baud_clk     in   1          clock shared with the SIPO
//   reset_n      in   1          asynchronous active-low reset
//   enable       in   1          1 = accept new frames (FIFO drains regardless)
//   rx_active    in   1          SIPO busy flag, feeds the stuck-line watchdog
//   frame_done   in   1          SIPO frame received level
//   frame_in     in   FRAME_W    {stop(s), parity, data LSB-first, start}
//   rx_data      out  DATA_BITS  FIFO head byte
//   rx_valid     out  1          FIFO non-empty
//   rx_ready     in   1          host takes the head byte this cycle
//   fifo_count   out  CW         entries held, 0..FIFO_DEPTH
//   parity_err   out  1          sticky: parity check failed
//   frame_err    out  1          sticky: bad start/stop or rx_active stuck high
//   overrun_err  out  1          sticky: byte or frame lost
//   err_clr      in   1          clears all sticky flags
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for a frame_done rising edge; latches frame_in on it
//   ST_CHECK | registers start/stop/parity check results of the captured frame
//   ST_WRITE | pushes the byte or raises the matching error flag
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int FRAME_W   = 1 + DATA_BITS + PARITY_EN + STOP_BITS,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 rx_active,
    input  logic                 frame_done,
    input  logic [FRAME_W-1:0]   frame_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CW-1:0]        fifo_count,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);

    localparam int   PTR_W       = $clog2(FIFO_DEPTH);
    localparam int   WD_MAX      = FRAME_W + 2;
    localparam int   WD_W        = $clog2(WD_MAX + 1);
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Frame edge detect
    // ------------------------------------------------------------------
    logic r_done_q;
    logic r_armed;
    logic w_edge;

    // r_armed stays low after reset until frame_done has been seen low, so a
    // level that was already high when reset released is not taken as a frame.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_done_q <= frame_done;
            if (!frame_done) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_edge = enable & frame_done & ~r_done_q & r_armed;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic w_ld_cap;
    logic w_ld_chk;
    logic w_wr_act;
    logic w_busy_edge;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_cap    = 1'b0;
        w_ld_chk    = 1'b0;
        w_wr_act    = 1'b0;
        w_busy_edge = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_ld_cap    = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_ld_chk    = 1'b1;
                w_busy_edge = w_edge;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_wr_act    = 1'b1;
                w_busy_edge = w_edge;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture and check registers
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] r_cap;
    logic               r_start_ok;
    logic               r_stop_ok;
    logic               r_parity_ok;
    logic               w_start_ok;
    logic               w_stop_ok;
    logic               w_parity_ok;

    assign w_start_ok = ~r_cap[0];
    assign w_stop_ok  = &r_cap[FRAME_W-1 -: STOP_BITS];

    generate
        if (PARITY_EN != 0) begin : g_par
            assign w_parity_ok = ~(^r_cap[DATA_BITS:1] ^ r_cap[DATA_BITS+1] ^ PAR_ODD_BIT);
        end else begin : g_nopar
            assign w_parity_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap       <= '0;
            r_start_ok  <= 1'b0;
            r_stop_ok   <= 1'b0;
            r_parity_ok <= 1'b0;
        end else begin
            if (w_ld_cap) begin
                r_cap <= frame_in;
            end
            if (w_ld_chk) begin
                r_start_ok  <= w_start_ok;
                r_stop_ok   <= w_stop_ok;
                r_parity_ok <= w_parity_ok;
            end
        end
    end

    // ------------------------------------------------------------------
    // WRITE decisions
    // ------------------------------------------------------------------
    logic w_frame_bad;
    logic w_parity_bad;
    logic w_push_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_fifo_ovr;

    assign w_frame_bad  = w_wr_act & ~(r_start_ok & r_stop_ok);
    assign w_parity_bad = w_wr_act &  r_start_ok & r_stop_ok & ~r_parity_ok;
    assign w_push_req   = w_wr_act &  r_start_ok & r_stop_ok &  r_parity_ok;

    // A full FIFO still takes the new byte if the host pops in the same cycle.
    assign w_full     = (fifo_count == CW'(FIFO_DEPTH));
    assign w_pop      = rx_valid & rx_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_fifo_ovr = w_push_req & w_full & ~w_pop;

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CW-1:0]        r_count;

    // Storage is cleared on reset so rx_data reads zero afterwards.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_cap[DATA_BITS:1];
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign fifo_count = r_count;
    assign rx_valid   = (r_count != '0);
    assign rx_data    = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Stuck-line watchdog
    // ------------------------------------------------------------------
    logic [WD_W-1:0] r_wd;
    logic            w_wd_trip;

    // Saturating at WD_MAX means the trip fires only on the step into WD_MAX,
    // giving one frame_err per continuous rx_active high period.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd <= '0;
        end else if (!rx_active) begin
            r_wd <= '0;
        end else if (r_wd != WD_W'(WD_MAX)) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    assign w_wd_trip = rx_active & (r_wd == WD_W'(WD_MAX - 1));

    // ------------------------------------------------------------------
    // Sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    logic r_parity_err;
    logic r_frame_err;
    logic r_overrun_err;
    logic w_frame_set;
    logic w_overrun_set;

    assign w_frame_set   = w_frame_bad | w_wd_trip;
    assign w_overrun_set = w_fifo_ovr | w_busy_edge;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_parity_err  <= w_parity_bad  | (r_parity_err  & ~err_clr);
            r_frame_err   <= w_frame_set   | (r_frame_err   & ~err_clr);
            r_overrun_err <= w_overrun_set | (r_overrun_err & ~err_clr);
        end
    end

    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (byte queue, pending-frame delay, consecutive-active
// counter) predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH  = 4;
    localparam int WD_LIM = 13;

    logic        baud_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        rx_active = 1'b0;
    logic        frame_done = 1'b0;
    logic [10:0] frame_in = '0;
    logic        rx_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  fifo_count;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;

    uart_rx_ctrl dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .rx_active   (rx_active),
        .frame_done  (frame_done),
        .frame_in    (frame_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr)
    );

    always #5 baud_clk = ~baud_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned m_q[$];
    bit           m_perr, m_ferr, m_oerr;
    bit           m_pend;
    int           m_pdly;
    logic [10:0]  m_pframe;
    bit           m_prev, m_armed;
    int           m_wd;

    task automatic model_clear();
        m_q.delete();
        m_perr = 0; m_ferr = 0; m_oerr = 0;
        m_pend = 0; m_pdly = 0; m_pframe = '0;
        m_prev = 0; m_armed = 0; m_wd = 0;
    endtask

    // Applies one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit           pset, fset, oset, pop, push, busy, edge_seen;
        bit           start_ok, stop_ok, par_ok;
        byte unsigned d;
        pset = 0; fset = 0; oset = 0; push = 0;
        d = 0;
        if (!reset_n) begin
            model_clear();
            return;
        end
        pop  = (m_q.size() != 0) && rx_ready;
        busy = m_pend;
        if (m_pend) begin
            m_pdly--;
            if (m_pdly == 0) begin
                m_pend   = 0;
                start_ok = (m_pframe[0] == 1'b0);
                stop_ok  = (m_pframe[10] == 1'b1);
                d        = m_pframe[8:1];
                par_ok   = ((^d) ^ m_pframe[9]) == 1'b0;
                if (!start_ok || !stop_ok) fset = 1;
                else if (!par_ok) pset = 1;
                else if (m_q.size() < DEPTH || pop) push = 1;
                else oset = 1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(d);
        edge_seen = enable && frame_done && !m_prev && m_armed;
        if (edge_seen) begin
            if (busy) oset = 1;
            else begin
                m_pend   = 1;
                m_pdly   = 2;
                m_pframe = frame_in;
            end
        end
        if (!frame_done) m_armed = 1;
        m_prev = frame_done;
        if (rx_active) begin
            if (m_wd < WD_LIM) begin
                m_wd++;
                if (m_wd == WD_LIM) fset = 1;
            end
        end else begin
            m_wd = 0;
        end
        m_perr = pset | (m_perr & !err_clr);
        m_ferr = fset | (m_ferr & !err_clr);
        m_oerr = oset | (m_oerr & !err_clr);
    endtask

    task automatic compare_all();
        chk_eq("rx_valid", 32'(rx_valid), 32'(m_q.size() != 0));
        chk_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        if (m_q.size() != 0) chk_eq("rx_data", 32'(rx_data), 32'(m_q[0]));
        chk_eq("parity_err", 32'(parity_err), 32'(m_perr));
        chk_eq("frame_err", 32'(frame_err), 32'(m_ferr));
        chk_eq("overrun_err", 32'(overrun_err), 32'(m_oerr));
    endtask

    task automatic tick();
        @(posedge baud_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [10:0] f, input int hold);
        frame_in   = f;
        frame_done = 1'b1;
        repeat (hold) tick();
        frame_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    function automatic logic [10:0] good_frame(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    function automatic logic [10:0] rand_frame();
        logic [7:0]  d;
        logic [10:0] f;
        int          b;
        d = 8'($urandom);
        f = good_frame(d);
        if ($urandom_range(0, 9) < 3) begin
            b = int'($urandom_range(0, 10));
            f[b] = ~f[b];
        end
        return f;
    endfunction

    int fd_hold, fd_gap, act_left;

    initial begin
        model_clear();
        // reset state
        repeat (2) tick();
        chk_eq("rst_rx_data", 32'(rx_data), 32'h0);
        chk_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk_eq("rst_count", 32'(fifo_count), 32'h0);
        chk_eq("rst_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // good frame then pop
        send(11'h554, 1);
        chk_eq("good_valid", 32'(rx_valid), 32'h1);
        chk_eq("good_data", 32'(rx_data), 32'hAA);
        chk_eq("good_count", 32'(fifo_count), 32'h1);
        chk_eq("good_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk_eq("pop_valid", 32'(rx_valid), 32'h0);
        chk_eq("pop_count", 32'(fifo_count), 32'h0);

        // parity error and clear
        send(11'h6AA, 1);
        chk_eq("par_err", 32'(parity_err), 32'h1);
        chk_eq("par_count", 32'(fifo_count), 32'h0);
        clear_flags();
        chk_eq("par_clr", 32'(parity_err), 32'h0);

        // framing error, then stuck rx_active watchdog
        send(11'h000, 1);
        chk_eq("frm_err", 32'(frame_err), 32'h1);
        chk_eq("frm_count", 32'(fifo_count), 32'h0);
        clear_flags();
        rx_active = 1'b1;
        repeat (12) tick();
        chk_eq("wd_before", 32'(frame_err), 32'h0);
        tick();
        chk_eq("wd_at13", 32'(frame_err), 32'h1);
        tick();
        rx_active = 1'b0;
        tick();
        clear_flags();

        // overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send(good_frame(8'(i)), 1);
        chk_eq("ovr_count", 32'(fifo_count), 32'h4);
        chk_eq("ovr_flag", 32'(overrun_err), 32'h1);
        rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk_eq("drain_data", 32'(rx_data), 32'(i));
            tick();
        end
        rx_ready = 1'b0;
        chk_eq("drain_count", 32'(fifo_count), 32'h0);
        clear_flags();
        for (int i = 0; i < 4; i++) send(good_frame(8'(8'h11 + i)), 1);
        frame_in   = good_frame(8'h06);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        chk_eq("full_pp_count", 32'(fifo_count), 32'h4);
        chk_eq("full_pp_ovr", 32'(overrun_err), 32'h0);
        chk_eq("full_pp_head", 32'(rx_data), 32'h12);
        rx_ready = 1'b1;
        repeat (4) tick();
        rx_ready = 1'b0;

        // held frame_done and disabled edge
        send(good_frame(8'h3C), 5);
        chk_eq("held_count", 32'(fifo_count), 32'h1);
        enable = 1'b0;
        send(good_frame(8'h5A), 1);
        enable = 1'b1;
        tick();
        chk_eq("dis_count", 32'(fifo_count), 32'h1);
        chk_eq("dis_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);

        // reset while in CHECK with two bytes queued
        send(good_frame(8'h77), 1);
        chk_eq("pre_rst_count", 32'(fifo_count), 32'h2);
        frame_in   = good_frame(8'h88);
        frame_done = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        chk_eq("mid_rst_data", 32'(rx_data), 32'h0);
        chk_eq("mid_rst_count", 32'(fifo_count), 32'h0);
        chk_eq("mid_rst_valid", 32'(rx_valid), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk_eq("stale_count", 32'(fifo_count), 32'h0);
        chk_eq("stale_flags", 32'({parity_err, frame_err, overrun_err}), 32'h0);
        frame_done = 1'b0;
        repeat (2) tick();

        // randomized traffic
        fd_hold = 0; fd_gap = 0; act_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (frame_done) begin
                if (fd_hold == 0) begin
                    frame_done = 1'b0;
                    fd_gap = int'($urandom_range(0, 5));
                end else begin
                    fd_hold--;
                end
            end else if (fd_gap == 0) begin
                frame_in   = rand_frame();
                frame_done = 1'b1;
                fd_hold    = int'($urandom_range(0, 4));
            end else begin
                fd_gap--;
            end
            if (act_left == 0) begin
                rx_active = 1'($urandom_range(0, 1));
                act_left  = rx_active ? int'($urandom_range(1, 18)) : int'($urandom_range(1, 6));
            end else begin
                act_left--;
            end
            enable   = ($urandom_range(0, 9) != 0);
            rx_ready = ($urandom_range(0, 2) == 0);
            err_clr  = ($urandom_range(0, 19) == 0);
            if (c == 700) begin
                reset_n = 1'b0;
                model_clear();
            end
            if (c == 703) reset_n = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART IP core. It sits directly behind the SIPO deserialiser and detects each completed frame from the SIPO's received flag. It validates the start, parity and stop bits, then queues good data bytes in a small first-word-fall-through FIFO with a valid/ready interface to the host. It reports parity, framing, overrun and stuck-line errors as sticky flags.

## Interface
- DATA_BITS, 8, data bits per frame
- PARITY_EN, 1, 1 = parity bit present in frame
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, ≥2)
- Derived: FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS; CW = $clog2(FIFO_DEPTH)+1

Ports:
- baud_clk  in  1  sole clock, same clock as the SIPO
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = accept frames; 0 = ignore new frames (FIFO still drains)
- rx_active  in  1  SIPO active_flag
- frame_done  in  1  SIPO recieved_flag (level, may stay high for several cycles)
- frame_in  in  FRAME_W  SIPO data_parll; [0] start, [DATA_BITS:1] data LSB-first, next bit parity (if PARITY_EN), top STOP_BITS bits stop
- rx_data  out  DATA_BITS  FIFO head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  host accepts the head byte this cycle
- fifo_count  out  CW  entries held, 0..FIFO_DEPTH
- parity_err, frame_err, overrun_err  out  1 each  sticky error flags
- err_clr  in  1  clears all sticky flags

## Operation
- Frame detect: register frame_done and detect its rising edge (prev=0, now=1). Only edges sampled with enable=1 count.
- FSM states:
  - IDLE: on an edge, latch frame_in into the capture register and go to CHECK.
  - CHECK: register start_ok (bit0==0), stop_ok (all stop bits==1), parity_ok (data XOR parity XOR PARITY_ODD == 0; forced 1 when PARITY_EN=0). Go to WRITE.
  - WRITE: act on the registered checks, then return to IDLE.
    - Stop or start bad: set frame_err and discard.
    - Otherwise parity bad: set parity_err and discard.
    - Otherwise FIFO has room: push data.
    - Otherwise: set overrun_err and discard the new byte.
- Frame edge seen in CHECK or WRITE: set overrun_err and drop that frame; the frame in flight completes normally.
- FIFO:
  - Circular buffer, FWFT. rx_data = mem[rd_ptr]; rx_valid = (fifo_count != 0).
  - Pop on rx_valid & rx_ready.
  - When full, a push is accepted only if a pop occurs in the same cycle; count is then unchanged.
  - Push and pop together when not full: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Watchdog:
  - Counter increments while rx_active=1 and clears when rx_active=0; it saturates.
  - When it reaches FRAME_W+2, set frame_err once per continuous high period.
- Sticky flags: set has priority over err_clr in the same cycle.

## Timing
- Reset values: state IDLE, rx_valid 0, rx_data 0, fifo_count 0, all error flags 0, pointers 0, watchdog 0, edge register 0.
- Reset asserted mid-frame or mid-FSM: everything returns to reset values immediately and FIFO contents are discarded. After release, frame_done already high does not count as an edge until it has been seen low.
- Latency: let E be the posedge at which the frame_done edge is sampled.
  - CHECK occupies E+1; the WRITE action takes effect at E+2.
  - rx_valid (for an empty FIFO) and error flags are high after posedge E+2.
- Pop: rx_data and fifo_count update on the posedge where rx_valid & rx_ready; the next byte is visible in the same cycle after that edge.
- Error flags clear on the posedge after err_clr=1 (unless set in the same cycle).
- Throughput: one frame per 3 cycles; a SIPO frame spans ≥ FRAME_W cycles, so back-to-back frames never overrun the FSM.

## Test plan
- Good frame: frame_in=11'h554 (0xAA, even parity 0, stop 1), frame_done pulse, rx_ready=0 -> after E+2 rx_valid=1, rx_data=8'hAA, fifo_count=1, no flags; then rx_ready=1 for one cycle -> rx_valid=0, count=0.
- Parity error: frame_in=11'h6AA (0x55, parity bit 1) -> parity_err=1, FIFO unchanged; err_clr pulse -> parity_err=0.
- Framing error: frame_in=11'h000 (stop=0) -> frame_err=1, no push. Separately, hold rx_active high 14 cycles with no frame_done -> frame_err=1 at cycle 13.
- Overrun: 5 good frames 0x01..0x05 with rx_ready=0 -> fifo_count=4, overrun_err=1; drain yields 01,02,03,04 in order. Refill to full, then push with a simultaneous pop -> count stays 4, no overrun.
- Held flag / enable: frame_done held high 5 cycles -> exactly one push. Edge sampled with enable=0 -> no push and no flags.
- Reset mid-operation: assert reset_n=0 in CHECK with 2 bytes queued -> after release all outputs are 0, and the stale high frame_done causes no push.
